// File: rtl/arith_issue_sched_pkg.sv
// Shared types for the arithmetic issue queue: ALU op codes, queue entry layout
// and the default widths used by the scheduler.
package arith_issue_sched_pkg;

  localparam int AIQ_PREG_W = 6;
  localparam int AIQ_OP_W   = 4;
  localparam int AL_SIZE    = 32;
  localparam int AIQ_AL_W   = $clog2(AL_SIZE);

  typedef enum logic [AIQ_OP_W-1:0] {
    ALUCTL_ADD  = 4'd0,
    ALUCTL_SUB  = 4'd1,
    ALUCTL_AND  = 4'd2,
    ALUCTL_OR   = 4'd3,
    ALUCTL_XOR  = 4'd4,
    ALUCTL_SLL  = 4'd5,
    ALUCTL_SRL  = 4'd6,
    ALUCTL_SRA  = 4'd7,
    ALUCTL_SLT  = 4'd8,
    ALUCTL_SLTU = 4'd9,
    ALUCTL_LUI  = 4'd10
  } aluctl_e;

  typedef struct packed {
    logic [AIQ_OP_W-1:0]   op;
    logic                  uses_imm;
    logic [31:0]           imm;
    logic [AIQ_PREG_W-1:0] rs1;
    logic                  rs1_rdy;
    logic [AIQ_PREG_W-1:0] rs2;
    logic                  rs2_rdy;
    logic [AIQ_PREG_W-1:0] rd;
    logic                  uses_rd;
    logic [AIQ_AL_W-1:0]   al_idx;
  } aiq_entry_t;

endpackage

// File: rtl/arith_issue_sched_age_select.sv
// Age matrix for the issue queue; picks the oldest and second-oldest
// candidates as one-hot vectors.
module arith_issue_sched_age_select #(
  parameter int DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [DEPTH-1:0]                    vld,
  input  logic [DEPTH-1:0]                    cand,
  input  logic [1:0]                          wr_en,
  input  logic [1:0][$clog2(DEPTH)-1:0]       wr_idx,
  output logic [DEPTH-1:0]                    oldest,
  output logic [DEPTH-1:0]                    second
);

  localparam int IDX_W = $clog2(DEPTH);

  // age_q[i][j] = 1 : entry i is older than entry j
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] rest;

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = (wr_en[0] && wr_idx[0] == IDX_W'(i)) ||
               (wr_en[1] && wr_idx[1] == IDX_W'(i));
    end
  end

  always_comb begin
    logic blk;
    oldest = '0;
    second = '0;
    rest   = '0;
    blk    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blk = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && age_q[j][i]) blk = 1'b1;
      end
      oldest[i] = cand[i] & ~blk;
    end
    rest = cand & ~oldest;
    for (int i = 0; i < DEPTH; i++) begin
      blk = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && rest[j] && age_q[j][i]) blk = 1'b1;
      end
      second[i] = rest[i] & ~blk;
    end
  end

  // A newly written entry is younger than everything already present and
  // than the older dispatch slot written alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (hit[i]) begin
            age_q[i][j] <= wr_en[0] && wr_en[1] &&
                           wr_idx[0] == IDX_W'(i) && wr_idx[1] == IDX_W'(j);
          end else if (hit[j] && vld[i]) begin
            age_q[i][j] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/arith_issue_sched.sv
// Arithmetic issue queue and scheduler: holds renamed ALU uops until their
// sources are ready and issues the two oldest ready ones per cycle.
module arith_issue_sched
  import arith_issue_sched_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PREG_W = AIQ_PREG_W,
  parameter int OP_W   = AIQ_OP_W,
  parameter int AL_W   = AIQ_AL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_recall,
  input  logic [1:0]                disp_valid,
  input  logic [1:0][OP_W-1:0]      disp_op,
  input  logic [1:0]                disp_uses_imm,
  input  logic [1:0][31:0]          disp_imm,
  input  logic [1:0][PREG_W-1:0]    disp_rs1,
  input  logic [1:0]                disp_rs1_rdy,
  input  logic [1:0][PREG_W-1:0]    disp_rs2,
  input  logic [1:0]                disp_rs2_rdy,
  input  logic [1:0][PREG_W-1:0]    disp_rd,
  input  logic [1:0]                disp_uses_rd,
  input  logic [1:0][AL_W-1:0]      disp_al_idx,
  output logic                      disp_ready,
  input  logic [1:0]                wb_valid,
  input  logic [1:0][PREG_W-1:0]    wb_rd,
  output logic [1:0]                iss_valid,
  output logic [1:0][OP_W-1:0]      iss_op,
  output logic [1:0]                iss_uses_imm,
  output logic [1:0][31:0]          iss_imm,
  output logic [1:0][PREG_W-1:0]    iss_rs1,
  output logic [1:0][PREG_W-1:0]    iss_rs2,
  output logic [1:0][PREG_W-1:0]    iss_rd,
  output logic [1:0]                iss_uses_rd,
  output logic [1:0][AL_W-1:0]      iss_al_idx,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  function automatic logic wb_hit(input logic [PREG_W-1:0] tag,
                                  input logic [1:0] wv,
                                  input logic [1:0][PREG_W-1:0] wr);
    return (wv[0] && wr[0] == tag) || (wv[1] && wr[1] == tag);
  endfunction

  aiq_entry_t                  ent_q [DEPTH];
  aiq_entry_t                  new_ent [2];
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0]            cand, sel0, sel1, wr_mask;
  logic [1:0][DEPTH-1:0]       lane_sel;
  logic [1:0]                  lane_hit;
  logic [1:0]                  wr_en;
  logic [1:0][IDX_W-1:0]       wr_idx;
  logic [IDX_W-1:0]            free0, free1;
  logic                        found0, found1;
  logic [OCC_W-1:0]            n_wr, n_iss;

  assign disp_ready = occupancy <= OCC_W'(DEPTH - 2);
  assign wr_en      = disp_valid & {2{disp_ready & ~if_recall}};

  // Two lowest free slots, from registered validity only.
  always_comb begin
    free0  = '0;
    free1  = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld_q[i]) begin
        if (!found0) begin
          free0  = IDX_W'(i);
          found0 = 1'b1;
        end else if (!found1) begin
          free1  = IDX_W'(i);
          found1 = 1'b1;
        end
      end
    end
  end

  assign wr_idx[0] = free0;
  assign wr_idx[1] = wr_en[0] ? free1 : free0;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      new_ent[k].op       = disp_op[k];
      new_ent[k].uses_imm = disp_uses_imm[k];
      new_ent[k].imm      = disp_imm[k];
      new_ent[k].rs1      = disp_rs1[k];
      new_ent[k].rs1_rdy  = disp_rs1_rdy[k] || disp_rs1[k] == '0 ||
                            wb_hit(disp_rs1[k], wb_valid, wb_rd);
      new_ent[k].rs2      = disp_rs2[k];
      new_ent[k].rs2_rdy  = disp_rs2_rdy[k] || disp_uses_imm[k] || disp_rs2[k] == '0 ||
                            wb_hit(disp_rs2[k], wb_valid, wb_rd);
      new_ent[k].rd       = disp_rd[k];
      new_ent[k].uses_rd  = disp_uses_rd[k];
      new_ent[k].al_idx   = disp_al_idx[k];
    end
  end

  always_comb begin
    cand    = '0;
    wr_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i]    = vld_q[i] & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
      wr_mask[i] = (wr_en[0] && wr_idx[0] == IDX_W'(i)) ||
                   (wr_en[1] && wr_idx[1] == IDX_W'(i));
    end
  end

  arith_issue_sched_age_select #(.DEPTH(DEPTH)) u_age (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (if_recall),
    .vld    (vld_q),
    .cand   (cand),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .oldest (sel0),
    .second (sel1)
  );

  assign lane_sel = {sel1, sel0};
  assign lane_hit = {|sel1, |sel0};
  assign n_wr     = OCC_W'(wr_en[0]) + OCC_W'(wr_en[1]);
  assign n_iss    = OCC_W'(lane_hit[0]) + OCC_W'(lane_hit[1]);

  // Entry payload: dispatch write, otherwise wakeup of pending sources.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[0] && wr_idx[0] == IDX_W'(i)) begin
        ent_q[i] <= new_ent[0];
      end else if (wr_en[1] && wr_idx[1] == IDX_W'(i)) begin
        ent_q[i] <= new_ent[1];
      end else begin
        if (wb_hit(ent_q[i].rs1, wb_valid, wb_rd)) ent_q[i].rs1_rdy <= 1'b1;
        if (wb_hit(ent_q[i].rs2, wb_valid, wb_rd)) ent_q[i].rs2_rdy <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      occupancy <= '0;
    end else if (if_recall) begin
      vld_q     <= '0;
      occupancy <= '0;
    end else begin
      vld_q     <= (vld_q & ~sel0 & ~sel1) | wr_mask;
      occupancy <= occupancy + n_wr - n_iss;
    end
  end

  // Issue stage boundary: selected entries registered onto the lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid    <= '0;
      iss_op       <= '0;
      iss_uses_imm <= '0;
      iss_imm      <= '0;
      iss_rs1      <= '0;
      iss_rs2      <= '0;
      iss_rd       <= '0;
      iss_uses_rd  <= '0;
      iss_al_idx   <= '0;
    end else if (if_recall) begin
      iss_valid <= '0;
    end else begin
      iss_valid <= lane_hit;
      for (int l = 0; l < 2; l++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (lane_sel[l][i]) begin
            iss_op[l]       <= ent_q[i].op;
            iss_uses_imm[l] <= ent_q[i].uses_imm;
            iss_imm[l]      <= ent_q[i].imm;
            iss_rs1[l]      <= ent_q[i].rs1;
            iss_rs2[l]      <= ent_q[i].rs2;
            iss_rd[l]       <= ent_q[i].rd;
            iss_uses_rd[l]  <= ent_q[i].uses_rd;
            iss_al_idx[l]   <= ent_q[i].al_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_arith_issue_sched.sv
// Randomized and directed bench for arith_issue_sched with an age-ordered
// queue reference model and a cycle-stamped issue scoreboard.
module tb_arith_issue_sched;
  import arith_issue_sched_pkg::*;

  localparam int DEPTH  = 8;
  localparam int PREG_W = 6;
  localparam int OP_W   = 4;
  localparam int AL_W   = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   if_recall = 1'b0;
  logic [1:0]             disp_valid = '0;
  logic [1:0][OP_W-1:0]   disp_op = '0;
  logic [1:0]             disp_uses_imm = '0;
  logic [1:0][31:0]       disp_imm = '0;
  logic [1:0][PREG_W-1:0] disp_rs1 = '0;
  logic [1:0]             disp_rs1_rdy = '0;
  logic [1:0][PREG_W-1:0] disp_rs2 = '0;
  logic [1:0]             disp_rs2_rdy = '0;
  logic [1:0][PREG_W-1:0] disp_rd = '0;
  logic [1:0]             disp_uses_rd = '0;
  logic [1:0][AL_W-1:0]   disp_al_idx = '0;
  logic                   disp_ready;
  logic [1:0]             wb_valid = '0;
  logic [1:0][PREG_W-1:0] wb_rd = '0;
  logic [1:0]             iss_valid;
  logic [1:0][OP_W-1:0]   iss_op;
  logic [1:0]             iss_uses_imm;
  logic [1:0][31:0]       iss_imm;
  logic [1:0][PREG_W-1:0] iss_rs1, iss_rs2, iss_rd;
  logic [1:0]             iss_uses_rd;
  logic [1:0][AL_W-1:0]   iss_al_idx;
  logic [3:0]             occupancy;

  always #5 clk = ~clk;

  arith_issue_sched #(.DEPTH(DEPTH), .PREG_W(PREG_W), .OP_W(OP_W), .AL_W(AL_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_recall(if_recall),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_uses_imm(disp_uses_imm),
    .disp_imm(disp_imm), .disp_rs1(disp_rs1), .disp_rs1_rdy(disp_rs1_rdy),
    .disp_rs2(disp_rs2), .disp_rs2_rdy(disp_rs2_rdy), .disp_rd(disp_rd),
    .disp_uses_rd(disp_uses_rd), .disp_al_idx(disp_al_idx), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_uses_imm(iss_uses_imm),
    .iss_imm(iss_imm), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_uses_rd(iss_uses_rd), .iss_al_idx(iss_al_idx), .occupancy(occupancy)
  );

  typedef struct {
    logic [OP_W-1:0]   op;
    logic              uses_imm;
    logic [31:0]       imm;
    logic [PREG_W-1:0] rs1;
    logic              r1;
    logic [PREG_W-1:0] rs2;
    logic              r2;
    logic [PREG_W-1:0] rd;
    logic              uses_rd;
    logic [AL_W-1:0]   al;
  } uop_t;

  typedef struct {
    uop_t u;
    int   cyc;
    int   lane;
  } exp_t;

  uop_t            mq[$];     // waiting uops, oldest first
  uop_t            keep_q[$];
  exp_t            eq[$];     // expected issues, in presentation order
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_err = 0;
  int              m_lane;
  bit              m_acc;
  logic [AL_W-1:0] al_ctr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm, input string msg);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", nm, msg, cyc);
  endtask

  function automatic logic wbhit(input logic [PREG_W-1:0] t);
    return (wb_valid[0] && wb_rd[0] == t) || (wb_valid[1] && wb_rd[1] == t);
  endfunction

  function automatic uop_t mk_uop(input int k);
    uop_t u;
    u.op       = disp_op[k];
    u.uses_imm = disp_uses_imm[k];
    u.imm      = disp_imm[k];
    u.rs1      = disp_rs1[k];
    u.r1       = disp_rs1_rdy[k] || disp_rs1[k] == 0 || wbhit(disp_rs1[k]);
    u.rs2      = disp_rs2[k];
    u.r2       = disp_rs2_rdy[k] || disp_uses_imm[k] || disp_rs2[k] == 0 || wbhit(disp_rs2[k]);
    u.rd       = disp_rd[k];
    u.uses_rd  = disp_uses_rd[k];
    u.al       = disp_al_idx[k];
    return u;
  endfunction

  function automatic logic [63:0] pack_u(input uop_t u);
    return {3'b0, u.op, u.uses_imm, u.imm, u.rs1, u.rs2, u.rd, u.uses_rd, u.al};
  endfunction

  // Reference model: two oldest ready uops leave each cycle; the rest wake up;
  // dispatch is accepted only with at least two free places.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      eq.delete();
    end else begin
      cyc++;
      if (if_recall) begin
        mq.delete();
      end else begin
        m_acc  = (DEPTH - mq.size()) >= 2;
        m_lane = 0;
        keep_q.delete();
        for (int i = 0; i < mq.size(); i++) begin
          if (m_lane < 2 && mq[i].r1 && mq[i].r2) begin
            eq.push_back('{u: mq[i], cyc: cyc, lane: m_lane});
            m_lane++;
          end else begin
            uop_t w;
            w = mq[i];
            if (wbhit(w.rs1)) w.r1 = 1'b1;
            if (wbhit(w.rs2)) w.r2 = 1'b1;
            keep_q.push_back(w);
          end
        end
        mq = keep_q;
        if (m_acc) begin
          for (int k = 0; k < 2; k++) if (disp_valid[k]) mq.push_back(mk_uop(k));
        end
      end
    end
  end

  // Monitor: consumes expected issues as the lanes present them.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < 2; l++) begin
        if (iss_valid[l]) begin
          if (eq.size() == 0) begin
            flag("spurious_issue", $sformatf("lane %0d al_idx %0d valid, nothing expected", l, iss_al_idx[l]));
          end else begin
            exp_t e;
            e = eq.pop_front();
            chk($sformatf("issue_lane%0d_fields", l),
                {3'b0, iss_op[l], iss_uses_imm[l], iss_imm[l], iss_rs1[l], iss_rs2[l],
                 iss_rd[l], iss_uses_rd[l], iss_al_idx[l]}, pack_u(e.u));
            chk($sformatf("issue_lane%0d_timing", l), 64'(cyc), 64'(e.cyc));
            chk($sformatf("issue_lane%0d_lane", l), 64'(l), 64'(e.lane));
          end
        end
      end
      while (eq.size() > 0 && eq[0].cyc <= cyc) begin
        flag("missing_issue", $sformatf("al_idx %0d lane %0d not presented", eq[0].u.al, eq[0].lane));
        void'(eq.pop_front());
      end
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("disp_ready", 64'(disp_ready), 64'((DEPTH - mq.size()) >= 2));
    end
  end

  task automatic idle();
    disp_valid = '0;
    wb_valid   = '0;
    if_recall  = 1'b0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      idle();
    end
  endtask

  task automatic set_slot(input int k, input logic [OP_W-1:0] op, input logic uimm,
                          input logic [PREG_W-1:0] rs1, input logic r1,
                          input logic [PREG_W-1:0] rs2, input logic r2);
    disp_valid[k]    = 1'b1;
    disp_op[k]       = op;
    disp_uses_imm[k] = uimm;
    disp_imm[k]      = $urandom;
    disp_rs1[k]      = rs1;
    disp_rs1_rdy[k]  = r1;
    disp_rs2[k]      = rs2;
    disp_rs2_rdy[k]  = r2;
    disp_rd[k]       = PREG_W'($urandom);
    disp_uses_rd[k]  = 1'($urandom);
    disp_al_idx[k]   = al_ctr;
    al_ctr++;
  endtask

  task automatic set_wb(input int p, input logic [PREG_W-1:0] tag);
    wb_valid[p] = 1'b1;
    wb_rd[p]    = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    @(negedge clk);
    chk("reset_iss_valid", 64'(iss_valid), 64'(0));
    chk("reset_occupancy", 64'(occupancy), 64'(0));
    chk("reset_iss_al_idx", 64'(iss_al_idx), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_disp_ready", 64'(disp_ready), 64'(1));

    // Two ready ADDs, al_idx 3 and 4.
    al_ctr = 5'd3;
    set_slot(0, ALUCTL_ADD, 1'b1, 6'd0, 1'b1, 6'd0, 1'b0);
    set_slot(1, ALUCTL_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    tick(4);

    // SUB waiting on rs1=5, woken from writeback port 1 a few cycles later.
    set_slot(0, ALUCTL_SUB, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0);
    tick();
    tick(2);
    set_wb(1, 6'd5);
    tick();
    tick(4);

    // Three ready uops A, B, C in age order.
    set_slot(0, ALUCTL_AND, 1'b0, 6'd3, 1'b1, 6'd4, 1'b1);
    set_slot(1, ALUCTL_OR, 1'b0, 6'd3, 1'b1, 6'd4, 1'b1);
    tick();
    set_slot(0, ALUCTL_XOR, 1'b1, 6'd3, 1'b1, 6'd0, 1'b0);
    tick();
    tick(4);

    // Fill with seven uops waiting on tag 9, then wake them all at once.
    for (int c = 0; c < 3; c++) begin
      set_slot(0, ALUCTL_SLL, 1'b1, 6'd9, 1'b0, 6'd0, 1'b0);
      set_slot(1, ALUCTL_SRL, 1'b0, 6'd9, 1'b0, 6'd7, 1'b1);
      tick();
    end
    set_slot(1, ALUCTL_SRA, 1'b1, 6'd9, 1'b0, 6'd0, 1'b0);
    tick();
    set_slot(0, ALUCTL_ADD, 1'b1, 6'd0, 1'b1, 6'd0, 1'b0);
    tick();
    set_wb(0, 6'd9);
    tick();
    tick(8);

    // Recall with four waiting entries and a simultaneous dispatch pair.
    for (int c = 0; c < 2; c++) begin
      set_slot(0, ALUCTL_SLT, 1'b1, 6'd10, 1'b0, 6'd0, 1'b0);
      set_slot(1, ALUCTL_SLTU, 1'b0, 6'd11, 1'b1, 6'd10, 1'b0);
      tick();
    end
    tick();
    if_recall = 1'b1;
    set_slot(0, ALUCTL_ADD, 1'b1, 6'd0, 1'b1, 6'd0, 1'b0);
    set_slot(1, ALUCTL_ADD, 1'b1, 6'd0, 1'b1, 6'd0, 1'b0);
    tick();
    set_wb(0, 6'd10);
    set_wb(1, 6'd11);
    tick();
    tick(4);

    // Randomized traffic with occasional recall.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 2) != 0)
          set_slot(k, OP_W'($urandom_range(0, 10)), 1'($urandom),
                   PREG_W'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                   PREG_W'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 4) < 3) set_wb(k, PREG_W'($urandom_range(1, 15)));
      end
      if_recall = ($urandom_range(0, 59) == 0);
      tick();
    end

    // Reset asserted mid-traffic with five waiting entries.
    for (int c = 0; c < 2; c++) begin
      set_slot(0, ALUCTL_ADD, 1'b1, 6'd12, 1'b0, 6'd0, 1'b0);
      set_slot(1, ALUCTL_ADD, 1'b1, 6'd12, 1'b0, 6'd0, 1'b0);
      tick();
    end
    set_slot(0, ALUCTL_ADD, 1'b1, 6'd12, 1'b0, 6'd0, 1'b0);
    set_slot(1, ALUCTL_SUB, 1'b1, 6'd0, 1'b1, 6'd0, 1'b0);
    tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_iss_valid", 64'(iss_valid), 64'(0));
    chk("midreset_occupancy", 64'(occupancy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_disp_ready", 64'(disp_ready), 64'(1));
    set_wb(0, 6'd12);
    tick();
    tick(4);

    tick(20);
    chk("drained_expectations", 64'(eq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
